// File: rtl/ahb_ctrl_master_if.sv
// Command/response handshake plus AHB-Lite master bus signals for ahb_ctrl_master.
// The master modport is the controller's view; the slave modport is the
// view of whatever drives commands and models the AHB slave.
interface ahb_ctrl_master_if;
    // command channel
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic        cmd_poll;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_wdata;
    // response channel
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    // AHB-Lite bus
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic [1:0]  HRESP;

    modport master (
        input  cmd_valid, cmd_write, cmd_poll, cmd_addr, cmd_size, cmd_wdata,
        input  rsp_ready, HRDATA, HREADY, HRESP,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output HADDR, HTRANS, HWRITE, HSIZE, HWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_poll, cmd_addr, cmd_size, cmd_wdata,
        output rsp_ready, HRDATA, HREADY, HRESP,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  HADDR, HTRANS, HWRITE, HSIZE, HWDATA
    );
endinterface

// File: rtl/ahb_ctrl_master.sv
// Single-outstanding AHB-Lite master: one command becomes one bus transfer,
// or in poll mode a series of reads of one register until masked bits go
// nonzero or the read limit is reached. All outputs come straight from flops.
module ahb_ctrl_master #(
    parameter int POLL_GAP = 4,
    parameter int POLL_MAX = 1024,
    parameter int CNT_W    = 16
) (
    input logic               HCLK,
    input logic               HRESET,
    ahb_ctrl_master_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_GAP  = 3'd3,
        S_RESP = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] POLL_MAX_C = CNT_W'(POLL_MAX);
    localparam logic [CNT_W-1:0] GAP_LAST_C = CNT_W'((POLL_GAP > 32'sd0) ? (POLL_GAP - 32'sd1) : 32'sd0);
    localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO_C = CNT_W'(0);

    // Replicate the write value across every byte lane the transfer size covers.
    function automatic logic [31:0] replicate_wdata(input logic [2:0] size, input logic [31:0] data);
        logic [31:0] r;
        case (size)
            3'b000:  r = {4{data[7:0]}};
            3'b001:  r = {2{data[15:0]}};
            default: r = data;
        endcase
        return r;
    endfunction

    // Pick the addressed lane out of HRDATA and zero-extend it.
    function automatic logic [31:0] select_lane(input logic [2:0] size, input logic [1:0] addr_lo,
                                                input logic [31:0] data);
        logic [31:0] r;
        case (size)
            3'b000: begin
                case (addr_lo)
                    2'b00:   r = {24'h000000, data[7:0]};
                    2'b01:   r = {24'h000000, data[15:8]};
                    2'b10:   r = {24'h000000, data[23:16]};
                    default: r = {24'h000000, data[31:24]};
                endcase
            end
            3'b001:  r = addr_lo[1] ? {16'h0000, data[31:16]} : {16'h0000, data[15:0]};
            default: r = data;
        endcase
        return r;
    endfunction

    state_t            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic [31:0]       haddr_q, haddr_d;
    logic [1:0]        htrans_q, htrans_d;
    logic              hwrite_q, hwrite_d;
    logic [2:0]        hsize_q, hsize_d;
    logic [31:0]       hwdata_q, hwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic              poll_q, poll_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [31:0]       rdata_lane_s;
    logic              unused_hresp_s;

    assign rdata_lane_s   = select_lane(hsize_q, haddr_q[1:0], bus.HRDATA);
    assign unused_hresp_s = bus.HRESP[1];

    // Next-state and next-output computation for the transfer FSM.
    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        haddr_d       = haddr_q;
        htrans_d      = htrans_q;
        hwrite_d      = hwrite_q;
        hsize_d       = hsize_q;
        hwdata_d      = hwdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        poll_d        = poll_q;
        wdata_d       = wdata_q;
        rd_cnt_d      = rd_cnt_q;
        gap_cnt_d     = gap_cnt_q;

        case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                if (bus.cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    haddr_d     = bus.cmd_addr;
                    hwrite_d    = bus.cmd_write;
                    hsize_d     = bus.cmd_size;
                    htrans_d    = 2'b10;
                    // a poll request that is also a write is just a write
                    poll_d      = bus.cmd_poll & ~bus.cmd_write;
                    wdata_d     = bus.cmd_wdata;
                    rd_cnt_d    = CNT_ONE_C;
                    gap_cnt_d   = CNT_ZERO_C;
                    state_d     = S_ADDR;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_ADDR: begin
                if (bus.HREADY) begin
                    htrans_d = 2'b00;
                    if (hwrite_q) begin
                        hwdata_d = replicate_wdata(hsize_q, wdata_q);
                    end else begin
                        hwdata_d = hwdata_q;
                    end
                    state_d = S_DATA;
                end else begin
                    state_d = S_ADDR;
                end
            end

            S_DATA: begin
                if (bus.HREADY) begin
                    htrans_d = 2'b00;
                    if (bus.HRESP[0]) begin
                        // error ends the command, including any poll in progress
                        rsp_rdata_d = rdata_lane_s;
                        rsp_err_d   = 1'b1;
                        rsp_valid_d = 1'b1;
                        state_d     = S_RESP;
                    end else if (!poll_q) begin
                        rsp_rdata_d = hwrite_q ? 32'h00000000 : rdata_lane_s;
                        rsp_valid_d = 1'b1;
                        state_d     = S_RESP;
                    end else if ((rdata_lane_s & wdata_q) != 32'h00000000) begin
                        rsp_rdata_d = rdata_lane_s;
                        rsp_valid_d = 1'b1;
                        state_d     = S_RESP;
                    end else if (rd_cnt_q == POLL_MAX_C) begin
                        rsp_rdata_d   = rdata_lane_s;
                        rsp_timeout_d = 1'b1;
                        rsp_valid_d   = 1'b1;
                        state_d       = S_RESP;
                    end else if (POLL_GAP == 32'sd0) begin
                        rsp_rdata_d = rdata_lane_s;
                        htrans_d    = 2'b10;
                        rd_cnt_d    = rd_cnt_q + CNT_ONE_C;
                        state_d     = S_ADDR;
                    end else begin
                        rsp_rdata_d = rdata_lane_s;
                        gap_cnt_d   = CNT_ZERO_C;
                        state_d     = S_GAP;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end

            S_GAP: begin
                htrans_d = 2'b00;
                if (gap_cnt_q == GAP_LAST_C) begin
                    gap_cnt_d = CNT_ZERO_C;
                    htrans_d  = 2'b10;
                    rd_cnt_d  = rd_cnt_q + CNT_ONE_C;
                    state_d   = S_ADDR;
                end else begin
                    gap_cnt_d = gap_cnt_q + CNT_ONE_C;
                    state_d   = S_GAP;
                end
            end

            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d   = 1'b0;
                    rsp_err_d     = 1'b0;
                    rsp_timeout_d = 1'b0;
                    cmd_ready_d   = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end

            default: begin
                state_d     = S_IDLE;
                htrans_d    = 2'b00;
                cmd_ready_d = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q       <= S_IDLE;
            cmd_ready_q   <= 1'b0;
            haddr_q       <= 32'h00000000;
            htrans_q      <= 2'b00;
            hwrite_q      <= 1'b0;
            hsize_q       <= 3'b010;
            hwdata_q      <= 32'h00000000;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'h00000000;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            poll_q        <= 1'b0;
            wdata_q       <= 32'h00000000;
            rd_cnt_q      <= CNT_ZERO_C;
            gap_cnt_q     <= CNT_ZERO_C;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            haddr_q       <= haddr_d;
            htrans_q      <= htrans_d;
            hwrite_q      <= hwrite_d;
            hsize_q       <= hsize_d;
            hwdata_q      <= hwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            poll_q        <= poll_d;
            wdata_q       <= wdata_d;
            rd_cnt_q      <= rd_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.HADDR       = haddr_q;
    assign bus.HTRANS      = htrans_q;
    assign bus.HWRITE      = hwrite_q;
    assign bus.HSIZE       = hsize_q;
    assign bus.HWDATA      = hwdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_ahb_ctrl_master.sv
// Testbench for ahb_ctrl_master: a behavioural AHB slave, a vector table of
// single transfers, and hand-written poll and reset sequences.
module tb_ahb_ctrl_master;
    localparam int POLL_GAP = 4;
    localparam int POLL_MAX = 8;

    logic HCLK   = 1'b0;
    logic HRESET = 1'b1;

    ahb_ctrl_master_if bus ();

    ahb_ctrl_master #(.POLL_GAP(POLL_GAP), .POLL_MAX(POLL_MAX), .CNT_W(16)) dut (
        .HCLK  (HCLK),
        .HRESET(HRESET),
        .bus   (bus)
    );

    always #5 HCLK = ~HCLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // ---------------- slave model ----------------
    int          sl_waits = 0;
    bit          sl_err   = 1'b0;
    logic [31:0] rq[$];
    int          nonseq_cnt = 0;
    int          nonseq_t[$];
    int          ncyc = 0;
    logic [31:0] log_haddr  = 32'h0;
    logic [31:0] log_hwdata = 32'h0;
    bit          dph = 1'b0;
    int          wl  = 0;
    logic [31:0] dph_rd = 32'h0;

    initial begin
        bus.HREADY = 1'b1;
        bus.HRESP  = 2'b00;
        bus.HRDATA = 32'h0;
        forever begin
            @(negedge HCLK);
            if (HRESET) begin
                dph        = 1'b0;
                bus.HREADY = 1'b1;
                bus.HRESP  = 2'b00;
            end else begin
                if (dph) begin
                    if (wl > 0) begin
                        bus.HREADY = 1'b0;
                        bus.HRESP  = sl_err ? 2'b01 : 2'b00;
                        wl--;
                    end else begin
                        bus.HREADY = 1'b1;
                        bus.HRESP  = sl_err ? 2'b01 : 2'b00;
                        bus.HRDATA = dph_rd;
                        log_hwdata = bus.HWDATA;
                        dph        = 1'b0;
                    end
                end else begin
                    bus.HREADY = 1'b1;
                    bus.HRESP  = 2'b00;
                end
                if (bus.HTRANS == 2'b10) begin
                    dph       = 1'b1;
                    wl        = sl_err ? 1 : sl_waits;
                    dph_rd    = (rq.size() > 0) ? rq.pop_front() : 32'h0;
                    log_haddr = bus.HADDR;
                    nonseq_cnt++;
                    nonseq_t.push_back(ncyc);
                end
            end
            ncyc++;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
        logic        chk_rdata;
    } exp_t;
    exp_t sb_q[$];

    task automatic run_cmd(input logic wr, input logic poll, input logic [31:0] addr,
                           input logic [2:0] size, input logic [31:0] wdata, input int hold,
                           input int exp_lat, input int exp_ns, input logic [31:0] exp_rdata,
                           input logic exp_err, input logic exp_to, input logic [31:0] exp_hwdata,
                           input string name);
        int   n;
        int   lat;
        int   ns0;
        exp_t e;
        e.rdata = exp_rdata; e.err = exp_err; e.to = exp_to; e.chk_rdata = !wr && !exp_err;
        sb_q.push_back(e);
        ns0 = nonseq_cnt;
        @(negedge HCLK);
        bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_poll = poll;
        bus.cmd_addr = addr; bus.cmd_size = size; bus.cmd_wdata = wdata;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 20) begin @(negedge HCLK); n++; end
        check32({name, "_accept"}, 32'(n < 20), 32'd1);
        @(negedge HCLK);
        bus.cmd_valid = 1'b0;
        lat = 1;
        check32({name, "_htrans"}, 32'(bus.HTRANS), 32'h2);
        check32({name, "_haddr"}, bus.HADDR, addr);
        check32({name, "_hwrite"}, 32'(bus.HWRITE), 32'(wr));
        check32({name, "_hsize"}, 32'(bus.HSIZE), 32'(size));
        while (bus.rsp_valid !== 1'b1 && lat < 200) begin @(negedge HCLK); lat++; end
        check32({name, "_latency"}, 32'(lat), 32'(exp_lat));
        repeat (hold) @(negedge HCLK);
        e = sb_q.pop_front();
        check32({name, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        check32({name, "_rsp_err"}, 32'(bus.rsp_err), 32'(e.err));
        check32({name, "_rsp_timeout"}, 32'(bus.rsp_timeout), 32'(e.to));
        if (e.chk_rdata) check32({name, "_rsp_rdata"}, bus.rsp_rdata, e.rdata);
        if (wr) check32({name, "_hwdata"}, log_hwdata, exp_hwdata);
        bus.rsp_ready = 1'b1;
        @(negedge HCLK);
        bus.rsp_ready = 1'b0;
        check32({name, "_rsp_cleared"}, {29'h0, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, 32'h0);
        check32({name, "_ready_again"}, 32'(bus.cmd_ready), 32'd1);
        check32({name, "_transfers"}, 32'(nonseq_cnt - ns0), 32'(exp_ns));
    endtask

    typedef struct {
        logic        wr;
        logic        poll;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] hrdata;
        int          waits;
        logic        err;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [31:0] exp_hwdata;
        int          exp_lat;
        string       name;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int base;
        vecs[0]  = '{1'b1, 1'b0, 32'h04, 3'b010, 32'h00000001, 32'h0, 0, 1'b0, 0, 32'h0, 1'b0, 32'h00000001, 3, "wr_word"};
        vecs[1]  = '{1'b0, 1'b0, 32'h09, 3'b000, 32'h0, 32'hAABBCCDD, 2, 1'b0, 0, 32'h000000CC, 1'b0, 32'h0, 5, "rd_byte_wait"};
        vecs[2]  = '{1'b1, 1'b0, 32'h02, 3'b001, 32'h1234ABCD, 32'h0, 0, 1'b0, 0, 32'h0, 1'b0, 32'hABCDABCD, 3, "wr_half"};
        vecs[3]  = '{1'b1, 1'b0, 32'h03, 3'b000, 32'h0000005A, 32'h0, 1, 1'b0, 0, 32'h0, 1'b0, 32'h5A5A5A5A, 4, "wr_byte_wait"};
        vecs[4]  = '{1'b0, 1'b0, 32'h0A, 3'b001, 32'h0, 32'hAABBCCDD, 0, 1'b0, 0, 32'h0000AABB, 1'b0, 32'h0, 3, "rd_half_hi"};
        vecs[5]  = '{1'b0, 1'b0, 32'h08, 3'b001, 32'h0, 32'hAABBCCDD, 0, 1'b0, 0, 32'h0000CCDD, 1'b0, 32'h0, 3, "rd_half_lo"};
        vecs[6]  = '{1'b0, 1'b0, 32'h08, 3'b010, 32'h0, 32'hDEADBEEF, 0, 1'b0, 2, 32'hDEADBEEF, 1'b0, 32'h0, 3, "rd_word_hold"};
        vecs[7]  = '{1'b0, 1'b0, 32'h00, 3'b000, 32'h0, 32'h11223344, 0, 1'b0, 0, 32'h00000044, 1'b0, 32'h0, 3, "rd_byte0"};
        vecs[8]  = '{1'b0, 1'b0, 32'h0B, 3'b000, 32'h0, 32'h11223344, 1, 1'b0, 0, 32'h00000011, 1'b0, 32'h0, 4, "rd_byte3"};
        vecs[9]  = '{1'b1, 1'b0, 32'h00, 3'b010, 32'h00000007, 32'h0, 0, 1'b1, 0, 32'h0, 1'b1, 32'h00000007, 4, "wr_error"};
        vecs[10] = '{1'b0, 1'b0, 32'h08, 3'b010, 32'h0, 32'h12345678, 0, 1'b1, 1, 32'h0, 1'b1, 32'h0, 4, "rd_error"};
        vecs[11] = '{1'b1, 1'b1, 32'h04, 3'b010, 32'h00000003, 32'h0, 0, 1'b0, 0, 32'h0, 1'b0, 32'h00000003, 3, "poll_write"};

        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_poll = 1'b0;
        bus.cmd_addr = 32'h0; bus.cmd_size = 3'b010; bus.cmd_wdata = 32'h0;
        bus.rsp_ready = 1'b0;

        // reset state
        repeat (3) @(negedge HCLK);
        check32("reset_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check32("reset_htrans", 32'(bus.HTRANS), 32'd0);
        check32("reset_haddr", bus.HADDR, 32'h0);
        check32("reset_hsize", 32'(bus.HSIZE), 32'h2);
        check32("reset_hwdata", bus.HWDATA, 32'h0);
        check32("reset_rsp", {29'h0, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, 32'h0);
        HRESET = 1'b0;
        @(negedge HCLK);
        check32("post_reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // single-transfer vectors
        for (int i = 0; i < 12; i++) begin
            sl_waits = vecs[i].waits;
            sl_err   = vecs[i].err;
            rq = {};
            rq.push_back(vecs[i].hrdata);
            run_cmd(vecs[i].wr, vecs[i].poll, vecs[i].addr, vecs[i].size, vecs[i].wdata,
                    vecs[i].hold, vecs[i].exp_lat, 1, vecs[i].exp_rdata, vecs[i].exp_err,
                    1'b0, vecs[i].exp_hwdata, vecs[i].name);
        end
        sl_err = 1'b0; sl_waits = 0;

        // poll that succeeds on the third read
        rq = {};
        rq.push_back(32'h0); rq.push_back(32'h0); rq.push_back(32'h1);
        base = nonseq_cnt;
        run_cmd(1'b0, 1'b1, 32'h08, 3'b010, 32'h00000001, 0, 15, 3, 32'h1, 1'b0, 1'b0, 32'h0, "poll_hit");
        check32("poll_hit_space1", 32'((nonseq_t.size() >= base + 3) ? nonseq_t[base+1] - nonseq_t[base] : -1), 32'(POLL_GAP + 2));
        check32("poll_hit_space2", 32'((nonseq_t.size() >= base + 3) ? nonseq_t[base+2] - nonseq_t[base+1] : -1), 32'(POLL_GAP + 2));
        check32("poll_hit_addr", log_haddr, 32'h08);

        // poll that never sees the bit and times out
        rq = {};
        run_cmd(1'b0, 1'b1, 32'h08, 3'b010, 32'h00000001, 0, 3 + (POLL_MAX - 1) * (POLL_GAP + 2),
                POLL_MAX, 32'h0, 1'b0, 1'b1, 32'h0, "poll_timeout");

        // reset while a poll read sits in its data phase
        rq = {};
        sl_waits = 3;
        @(negedge HCLK);
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_poll = 1'b1;
        bus.cmd_addr = 32'h08; bus.cmd_size = 3'b010; bus.cmd_wdata = 32'h1;
        check32("rst_poll_ready", 32'(bus.cmd_ready), 32'd1);
        @(negedge HCLK);
        bus.cmd_valid = 1'b0;
        @(negedge HCLK);
        HRESET = 1'b1;
        @(negedge HCLK);
        check32("rst_mid_htrans", 32'(bus.HTRANS), 32'd0);
        check32("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check32("rst_mid_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check32("rst_mid_haddr", bus.HADDR, 32'h0);
        @(negedge HCLK);
        HRESET = 1'b0;
        sl_waits = 0;
        @(negedge HCLK);
        check32("rst_release_ready", 32'(bus.cmd_ready), 32'd1);
        rq = {};
        rq.push_back(32'hCAFEF00D);
        run_cmd(1'b0, 1'b0, 32'h04, 3'b010, 32'h0, 0, 3, 1, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0, "after_reset_rd");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
